raster_reorder_n: RTL and testbench
===================================

# raster_reorder_n

Parametrised reorder/output stage for the N-engine Mandelbrot renderer. Each engine delivers its results in order, but the engines run at different speeds. This block buffers each engine's results in its own FIFO and emits a single raster-order pixel stream with first/last_x/last_y flags and ready/valid backpressure. It sits between the per-engine colour LUT outputs and the pixel-generator stream interface. It also checks every emitted pixel's coordinates against the raster position.

## Interface
- NUM_ENGINES, 12, number of engine input channels (≥2)
- FIFO_DEPTH, 4, entries per engine FIFO (power of 2, ≥2)
- COLOUR_WIDTH, 24, colour bits per pixel
- PIXEL_DATA_WIDTH, 10, width of x and y coordinates
- SCREEN_W, 640, pixels per line
- SCREEN_H, 480, lines per frame

Ports:
- clk  in  1  single clock, rising edge
- reset  in  1  synchronous, active-high
- in_valid  in  NUM_ENGINES  per-engine result valid
- in_ready  out  NUM_ENGINES  per-engine result accept
- in_x  in  NUM_ENGINES*PIXEL_DATA_WIDTH  packed x coordinates, engine i at [i*W +: W]
- in_y  in  NUM_ENGINES*PIXEL_DATA_WIDTH  packed y coordinates, same packing
- in_colour  in  NUM_ENGINES*COLOUR_WIDTH  packed colours
- out_ready  in  1  downstream accept
- out_valid  out  1  output pixel valid
- out_colour  out  COLOUR_WIDTH  output pixel colour
- first  out  1  pixel (0,0) of frame
- last_x  out  1  last pixel of line
- last_y  out  1  pixel on last line
- seq_error  out  1  sticky coordinate-mismatch flag

## Operation
- Pixel-to-engine assignment is fixed: raster index p within a frame, with p = y*SCREEN_W + x, belongs to engine (p mod NUM_ENGINES). The engine pointer restarts at 0 on every frame.
- Each engine has its own FIFO of FIFO_DEPTH entries holding {x, y, colour}.
  - A push occurs when in_valid[i] && in_ready[i].
  - in_ready[i] = !full[i].
- State:
  - eng_ptr: 0..NUM_ENGINES-1.
  - x_cnt: 0..SCREEN_W-1.
  - y_cnt: 0..SCREEN_H-1.
  - Per FIFO: read pointer, write pointer, and count. Count width is clog2(FIFO_DEPTH)+1.
- Output: out_valid = !empty[eng_ptr]. out_colour is the head colour of FIFO eng_ptr (show-ahead, combinational from FIFO storage).
- Flags, each gated by out_valid:
  - first = (x_cnt==0 && y_cnt==0).
  - last_x = (x_cnt==SCREEN_W-1).
  - last_y = (y_cnt==SCREEN_H-1).
- Transfer occurs when out_valid && out_ready. On a transfer:
  - Pop FIFO eng_ptr.
  - Increment eng_ptr, wrapping NUM_ENGINES-1→0.
  - Increment x_cnt; at SCREEN_W-1 it wraps to 0 and y_cnt increments.
  - At the last pixel (x_cnt=SCREEN_W-1, y_cnt=SCREEN_H-1): x_cnt, y_cnt and eng_ptr all go to 0. This end-of-frame reset of eng_ptr overrides the normal increment.
- Sequence check: on each transfer, if the head x≠x_cnt or head y≠y_cnt, set seq_error. The pixel is still emitted and the counters advance normally. seq_error clears only on reset.
- Out-of-order arrival: results from other engines are buffered. Output stalls (out_valid=0) until the engine at eng_ptr has data.
- Simultaneous push and pop on the same FIFO are legal. In that case count is unchanged, and both pointers advance.
- A full FIFO cannot push in the same cycle as its pop: in_ready is 0 while full. in_ready rises the cycle after the pop.

## Timing
- Reset (synchronous, one or more cycles):
  - All FIFOs are emptied.
  - eng_ptr, x_cnt, y_cnt = 0.
  - seq_error = 0.
  - out_valid, first, last_x, last_y = 0.
  - in_ready = all 0 during reset cycles and all 1 on the first cycle after reset.
- Reset mid-frame discards all buffered data. The next output is pixel (0,0) from engine 0.
- Latency: a push at edge n into an empty FIFO at eng_ptr gives out_valid=1 in cycle n+1. Throughput is one pixel per cycle when the data is available.
- out_colour and the flags are stable while out_valid && !out_ready.
- in_ready[i] depends only on registered count, with no combinational path from in_valid or out_ready.

## Test plan
- Basic raster. NUM_ENGINES=4, SCREEN_W=8, SCREEN_H=2, out_ready=1. Each engine pushes its pixels in order with correct coordinates.
  - Required: 16 outputs in raster order.
  - first on pixel 0 only; last_x on pixels 7 and 15; last_y on pixels 8–15.
  - seq_error stays 0.
- Out-of-order arrival. Engines 3, 2 and 1 push pixels 3, 2 and 1 in cycles 0–2; engine 0 pushes pixel 0 in cycle 5.
  - Required: out_valid=0 through cycle 5.
  - Pixels 0, 1, 2, 3 are emitted in cycles 6–9.
- Backpressure. FIFO_DEPTH=4, out_ready=0, engine 1 pushes continuously.
  - Required: in_ready[1] falls after the 4th push.
  - After engine 0 supplies pixel 0 and out_ready goes high, in_ready[1] returns to 1 the cycle after pixel 1 pops.
- Sequence error. Engine 2 pushes pixel 2 with x=5 instead of x=2.
  - Required: the pixel is still emitted.
  - seq_error=1 from the cycle after that transfer and stays 1 until reset.
- Frame wrap. NUM_ENGINES=3, SCREEN_W=8, SCREEN_H=2; 16 mod 3 = 1.
  - Required: pixel 15 comes from engine 0.
  - The next frame's pixel 0 also comes from engine 0 (eng_ptr is reset, not incremented to 1), with first=1.
- Reset mid-frame. Apply reset after 5 outputs while 3 FIFOs hold data.
  - Required: outputs are 0 during reset; all FIFOs are empty after reset.
  - The next output is (0,0) with first=1, and seq_error=0.

Source files
------------

// File: rtl/raster_reorder_n.sv
// Raster reorder stage: per-engine FIFOs merged back into one raster-order
// pixel stream with frame flags and a sticky coordinate check.
module raster_reorder_n #(
  parameter int NUM_ENGINES      = 12,
  parameter int FIFO_DEPTH       = 4,
  parameter int COLOUR_WIDTH     = 24,
  parameter int PIXEL_DATA_WIDTH = 10,
  parameter int SCREEN_W         = 640,
  parameter int SCREEN_H         = 480
) (
  input  logic                                     clk,
  input  logic                                     reset,
  input  logic [NUM_ENGINES-1:0]                   in_valid,
  output logic [NUM_ENGINES-1:0]                   in_ready,
  input  logic [NUM_ENGINES*PIXEL_DATA_WIDTH-1:0]  in_x,
  input  logic [NUM_ENGINES*PIXEL_DATA_WIDTH-1:0]  in_y,
  input  logic [NUM_ENGINES*COLOUR_WIDTH-1:0]      in_colour,
  input  logic                                     out_ready,
  output logic                                     out_valid,
  output logic [COLOUR_WIDTH-1:0]                  out_colour,
  output logic                                     first,
  output logic                                     last_x,
  output logic                                     last_y,
  output logic                                     seq_error
);

  localparam int W  = PIXEL_DATA_WIDTH;
  localparam int CW = COLOUR_WIDTH;
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int NW = PW + 1;
  localparam int EW = $clog2(NUM_ENGINES);

  logic [W-1:0]  x_mem [NUM_ENGINES][FIFO_DEPTH];
  logic [W-1:0]  y_mem [NUM_ENGINES][FIFO_DEPTH];
  logic [CW-1:0] c_mem [NUM_ENGINES][FIFO_DEPTH];

  logic [PW-1:0] rd_ptr [NUM_ENGINES];
  logic [PW-1:0] wr_ptr [NUM_ENGINES];
  logic [NW-1:0] count  [NUM_ENGINES];

  logic [NUM_ENGINES-1:0] full;
  logic [NUM_ENGINES-1:0] empty;
  logic [NUM_ENGINES-1:0] push;
  logic [NUM_ENGINES-1:0] pop;

  logic [EW-1:0] eng_ptr;
  logic [W-1:0]  x_cnt;
  logic [W-1:0]  y_cnt;
  logic [W-1:0]  head_x;
  logic [W-1:0]  head_y;
  logic          xfer;
  logic          end_x;
  logic          end_y;

  // ready is held low through reset so no result is lost to the clear
  assign in_ready = ~full & {NUM_ENGINES{~reset}};
  assign push     = in_valid & in_ready;

  assign out_valid  = ~reset & ~empty[eng_ptr];
  assign xfer       = out_valid & out_ready;
  assign head_x     = x_mem[eng_ptr][rd_ptr[eng_ptr]];
  assign head_y     = y_mem[eng_ptr][rd_ptr[eng_ptr]];
  assign out_colour = c_mem[eng_ptr][rd_ptr[eng_ptr]];

  assign end_x  = x_cnt == W'(SCREEN_W - 1);
  assign end_y  = y_cnt == W'(SCREEN_H - 1);
  assign first  = out_valid & (x_cnt == '0) & (y_cnt == '0);
  assign last_x = out_valid & end_x;
  assign last_y = out_valid & end_y;

  for (genvar g = 0; g < NUM_ENGINES; g++) begin : g_fifo
    assign full[g]  = count[g] == NW'(FIFO_DEPTH);
    assign empty[g] = count[g] == '0;
    assign pop[g]   = xfer & (eng_ptr == EW'(g));

    always_ff @(posedge clk) begin
      if (push[g]) begin
        x_mem[g][wr_ptr[g]] <= in_x[g*W +: W];
        y_mem[g][wr_ptr[g]] <= in_y[g*W +: W];
        c_mem[g][wr_ptr[g]] <= in_colour[g*CW +: CW];
      end
    end

    always_ff @(posedge clk) begin
      if (reset) begin
        rd_ptr[g] <= '0;
        wr_ptr[g] <= '0;
        count[g]  <= '0;
      end else begin
        if (push[g])
          wr_ptr[g] <= wr_ptr[g] + PW'(1);
        if (pop[g])
          rd_ptr[g] <= rd_ptr[g] + PW'(1);
        unique case ({push[g], pop[g]})
          2'b10:   count[g] <= count[g] + NW'(1);
          2'b01:   count[g] <= count[g] - NW'(1);
          default: count[g] <= count[g];
        endcase
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      eng_ptr   <= '0;
      x_cnt     <= '0;
      y_cnt     <= '0;
      seq_error <= 1'b0;
    end else if (xfer) begin
      if (head_x != x_cnt || head_y != y_cnt)
        seq_error <= 1'b1;
      // frame end restarts the engine rotation rather than continuing it
      if (end_x && end_y) begin
        eng_ptr <= '0;
        x_cnt   <= '0;
        y_cnt   <= '0;
      end else begin
        if (eng_ptr == EW'(NUM_ENGINES - 1))
          eng_ptr <= '0;
        else
          eng_ptr <= eng_ptr + EW'(1);
        if (end_x) begin
          x_cnt <= '0;
          y_cnt <= y_cnt + W'(1);
        end else begin
          x_cnt <= x_cnt + W'(1);
        end
      end
    end
  end

endmodule

// File: tb/tb_raster_reorder_n.sv
// Scoreboard bench for raster_reorder_n: random per-engine traffic against
// a raster-order reference, plus directed stall, backpressure and reset cases.
module tb_raster_reorder_n;

  localparam int NE   = 3;
  localparam int FD   = 4;
  localparam int CW   = 24;
  localparam int PDW  = 10;
  localparam int SW   = 8;
  localparam int SH   = 2;
  localparam int NPIX = SW * SH;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic [NE-1:0]     in_valid;
  logic [NE-1:0]     in_ready;
  logic [NE*PDW-1:0] in_x;
  logic [NE*PDW-1:0] in_y;
  logic [NE*CW-1:0]  in_colour;
  logic              out_ready;
  logic              out_valid;
  logic [CW-1:0]     out_colour;
  logic              first;
  logic              last_x;
  logic              last_y;
  logic              seq_error;

  typedef struct {
    logic [PDW-1:0] x;
    logic [PDW-1:0] y;
    logic [CW-1:0]  c;
  } ent_t;

  typedef struct {
    logic [CW-1:0] c;
    logic          f;
    logic          lx;
    logic          ly;
    logic          bad;
  } exp_t;

  ent_t pend [NE][$];
  exp_t exp_q [$];
  logic [NE-1:0] acc  = '0;
  logic [NE-1:0] hold = '0;
  int   vprob = 0;
  int   rprob = 0;
  int   n_chk = 0;
  int   n_pass = 0;
  int   n_out = 0;
  logic model_seq = 1'b0;

  always #10 clk = ~clk;

  raster_reorder_n #(
    .NUM_ENGINES(NE), .FIFO_DEPTH(FD), .COLOUR_WIDTH(CW),
    .PIXEL_DATA_WIDTH(PDW), .SCREEN_W(SW), .SCREEN_H(SH)
  ) dut (
    .clk(clk), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_x(in_x), .in_y(in_y), .in_colour(in_colour),
    .out_ready(out_ready), .out_valid(out_valid),
    .out_colour(out_colour), .first(first),
    .last_x(last_x), .last_y(last_y), .seq_error(seq_error)
  );

  task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  // slot +1 after each falling edge belongs to the main sequence
  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  // reference: pixel p sits at (p%SW, p/SW) and belongs to engine p%NE
  task automatic plan(int p, bit bad);
    ent_t en;
    exp_t ex;
    int x = p % SW;
    int y = p / SW;
    en.x = bad ? PDW'(5) : PDW'(x);
    en.y = PDW'(y);
    en.c = CW'($urandom);
    pend[p % NE].push_back(en);
    ex.c   = en.c;
    ex.f   = (p == 0);
    ex.lx  = (x == SW - 1);
    ex.ly  = (y == SH - 1);
    ex.bad = bad;
    exp_q.push_back(ex);
  endtask

  task automatic drain(int limit);
    int k = 0;
    while (exp_q.size() > 0 && k < limit) begin
      tick();
      k++;
    end
    chk("drain_done", exp_q.size(), 0);
  endtask

  task automatic do_reset(int n);
    reset = 1'b1;
    for (int i = 0; i < n; i++) begin
      #1;
      chk("rst_in_ready", in_ready, 0);
      chk("rst_out_valid", out_valid, 0);
      chk("rst_flags", {first, last_x, last_y}, 0);
      tick();
    end
    for (int e = 0; e < NE; e++) pend[e].delete();
    exp_q.delete();
    model_seq = 1'b0;
    hold = '0;
    reset = 1'b0;
    #1;
    chk("post_rst_in_ready", in_ready, {NE{1'b1}});
    chk("post_rst_out_valid", out_valid, 0);
    chk("post_rst_seq_error", seq_error, 0);
  endtask

  initial begin : drv
    in_valid  = '0;
    in_x      = '0;
    in_y      = '0;
    in_colour = '0;
    out_ready = 1'b0;
    forever begin
      @(negedge clk);
      #3;
      for (int e = 0; e < NE; e++) begin
        if (acc[e] && pend[e].size() > 0) void'(pend[e].pop_front());
        in_valid[e] = 1'b0;
        if (pend[e].size() > 0) begin
          in_x[e*PDW +: PDW]    = pend[e][0].x;
          in_y[e*PDW +: PDW]    = pend[e][0].y;
          in_colour[e*CW +: CW] = pend[e][0].c;
          in_valid[e] = !hold[e] && ($urandom_range(99) < vprob);
        end
      end
      out_ready = ($urandom_range(99) < rprob);
      #1;
      acc = in_valid & in_ready;
    end
  end

  initial begin : mon
    exp_t e;
    forever begin
      @(negedge clk);
      #6;
      if (!reset && out_valid && out_ready) begin
        n_out++;
        if (exp_q.size() == 0) begin
          chk("spurious_out", 1, 0);
        end else begin
          e = exp_q.pop_front();
          chk("colour", out_colour, e.c);
          chk("first", first, e.f);
          chk("last_x", last_x, e.lx);
          chk("last_y", last_y, e.ly);
          chk("seq_error", seq_error, model_seq);
          if (e.bad) model_seq = 1'b1;
        end
      end
    end
  end

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin : main
    logic [CW-1:0] c1;
    bit found;
    int base;
    int k;
    tick();
    do_reset(3);

    // random traffic over three frames, covers frame wrap with NE=3
    vprob = 60;
    rprob = 70;
    for (int f = 0; f < 3; f++)
      for (int p = 0; p < NPIX; p++) plan(p, 1'b0);
    drain(3000);

    // engine 0 late: output must wait, then 0,1,2 back to back
    vprob = 100;
    rprob = 100;
    hold = 3'b001;
    plan(0, 1'b0);
    plan(1, 1'b0);
    plan(2, 1'b0);
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("ooo_stall", out_valid, 0);
    end
    hold = '0;
    tick();
    chk("ooo_valid0", out_valid, 1);
    tick();
    chk("ooo_valid1", out_valid, 1);
    tick();
    chk("ooo_valid2", out_valid, 1);
    tick();
    chk("ooo_empty3", out_valid, 0);
    do_reset(2);

    // backpressure on engine 1
    hold = 3'b101;
    rprob = 0;
    vprob = 100;
    for (int p = 0; p < 14; p++) plan(p, 1'b0);
    c1 = exp_q[1].c;
    for (int i = 0; i < 8; i++) tick();
    chk("bp_full_ready", in_ready[1], 0);
    chk("bp_pending", pend[1].size(), 1);
    hold = 3'b100;
    rprob = 100;
    found = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      tick();
      #6;
      if (out_valid && out_ready && out_colour == c1) begin
        chk("bp_ready_at_pop", in_ready[1], 0);
        found = 1'b1;
      end
    end
    chk("bp_pop_seen", found, 1);
    tick();
    #6;
    chk("bp_ready_after_pop", in_ready[1], 1);
    hold = '0;
    drain(500);
    do_reset(1);

    // bad x on pixel 2
    vprob = 70;
    rprob = 70;
    for (int p = 0; p < NPIX; p++) plan(p, p == 2);
    drain(1000);
    chk("seq_sticky", seq_error, 1);
    tick();
    tick();
    chk("seq_sticky_later", seq_error, 1);
    do_reset(1);

    // reset mid-frame with data buffered
    vprob = 100;
    rprob = 40;
    for (int p = 0; p < NPIX; p++) plan(p, 1'b0);
    base = n_out;
    k = 0;
    while (n_out < base + 5 && k < 500) begin
      tick();
      k++;
    end
    chk("mid_outputs", n_out - base, 5);
    do_reset(2);
    vprob = 0;
    rprob = 100;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("mid_fifo_empty", out_valid, 0);
    end
    vprob = 70;
    rprob = 80;
    for (int p = 0; p < NPIX; p++) plan(p, 1'b0);
    drain(1000);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
